// File: rtl/spmv_ctrl_pkg.sv
// Shared state encoding and completion status codes for the SpMV iteration sequencer.
package spmv_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      SWAP,
      FINISH
   } state_t;

   localparam int STATUS_WIDTH = 2;

   localparam logic [STATUS_WIDTH-1:0] STATUS_OK      = 2'd0;
   localparam logic [STATUS_WIDTH-1:0] STATUS_ABORT   = 2'd1;
   localparam logic [STATUS_WIDTH-1:0] STATUS_TIMEOUT = 2'd2;

endpackage

// File: rtl/spmv_ctrl_watchdog.sv
// Per-kernel-run watchdog: counts enabled cycles since the last clear and flags the
// final allowed cycle. With TIMEOUT_CYCLES == 0 the counter is absent and expired stays low.
module spmv_ctrl_watchdog #(
   parameter int TIMEOUT_CYCLES = 0,
   parameter int TIMEOUT_WIDTH  = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_wdog
         localparam logic [TIMEOUT_WIDTH-1:0] LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

         logic [TIMEOUT_WIDTH-1:0] count_reg;

         always_ff @(posedge clk) begin
            if (rst || clear) begin
               count_reg <= '0;
            end else if (enable && (count_reg != LAST)) begin
               count_reg <= count_reg + TIMEOUT_WIDTH'(1);
            end
         end

         // Fires during the TIMEOUT_CYCLES-th enabled cycle so the run lasts exactly that long.
         assign expired = enable && (count_reg == LAST);
      end else begin : g_off
         localparam int unused_width = TIMEOUT_WIDTH;
         logic unused_inputs;
         assign unused_inputs = ^{clk, rst, clear, enable};
         assign expired       = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/spmv_iter_ctrl.sv
// Sequences N SpMV iterations: DMA replay request, kernel run, ping-pong flip, completion status.
// Optional performance counters are compiled in with SPMV_ITER_CTRL_PERF_EN.
module spmv_iter_ctrl
   import spmv_ctrl_pkg::*;
#(
   parameter int ITER_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 0,
   parameter int TIMEOUT_WIDTH  = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    abort,
   input  logic [ITER_WIDTH-1:0]   num_iters,
   output logic                    busy,
   output logic                    done,
   output logic [STATUS_WIDTH-1:0] status,
   output logic [ITER_WIDTH-1:0]   iter_count,
   output logic                    result_bank,
   output logic                    ping,
   output logic                    kernel_en,
   input  logic                    kernel_done,
   output logic                    dma_req,
`ifdef SPMV_ITER_CTRL_PERF_EN
   output logic [31:0]             perf_cycles,
   output logic [31:0]             perf_stall,
`endif
   input  logic                    dma_ack
);

   state_t                  state_reg, state_next;
   logic [ITER_WIDTH-1:0]   target_reg, target_next;
   logic [ITER_WIDTH-1:0]   iter_reg, iter_next;
   logic                    ping_reg, ping_next;
   logic [STATUS_WIDTH-1:0] status_reg, status_next;
   logic                    bank_reg, bank_next;
   logic [ITER_WIDTH:0]     iter_plus;
   logic                    timeout_hit;

   spmv_ctrl_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (state_reg != RUN),
      .enable (state_reg == RUN),
      .expired(timeout_hit)
   );

   // One extra bit so the terminal compare cannot wrap at the top of the range.
   assign iter_plus = {1'b0, iter_reg} + {{ITER_WIDTH{1'b0}}, 1'b1};

   always_comb begin
      state_next  = state_reg;
      target_next = target_reg;
      iter_next   = iter_reg;
      ping_next   = ping_reg;
      status_next = status_reg;
      bank_next   = bank_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               target_next = num_iters;
               iter_next   = '0;
               ping_next   = 1'b0;
               if (num_iters == '0) begin
                  state_next  = FINISH;
                  status_next = STATUS_OK;
                  bank_next   = 1'b0;
               end else begin
                  state_next = LOAD;
               end
            end
         end
         LOAD: begin
            if (abort) begin
               state_next  = FINISH;
               status_next = STATUS_ABORT;
               bank_next   = ping_reg;
            end else if (dma_ack) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_next  = FINISH;
               status_next = STATUS_ABORT;
               bank_next   = ping_reg;
            end else if (kernel_done) begin
               state_next = SWAP;
            end else if (timeout_hit) begin
               state_next  = FINISH;
               status_next = STATUS_TIMEOUT;
               bank_next   = ping_reg;
            end
         end
         SWAP: begin
            // Abort here wins over the flip: the bank still holds the last finished iterate.
            if (abort) begin
               state_next  = FINISH;
               status_next = STATUS_ABORT;
               bank_next   = ping_reg;
            end else begin
               ping_next = ~ping_reg;
               iter_next = (&iter_reg) ? iter_reg : iter_plus[ITER_WIDTH-1:0];
               if (iter_plus == {1'b0, target_reg}) begin
                  state_next  = FINISH;
                  status_next = STATUS_OK;
                  bank_next   = ~ping_reg;
               end else begin
                  state_next = LOAD;
               end
            end
         end
         FINISH: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         target_reg <= '0;
         iter_reg   <= '0;
         ping_reg   <= 1'b0;
         status_reg <= STATUS_OK;
         bank_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         target_reg <= target_next;
         iter_reg   <= iter_next;
         ping_reg   <= ping_next;
         status_reg <= status_next;
         bank_reg   <= bank_next;
      end
   end

   assign busy        = (state_reg != IDLE);
   assign done        = (state_reg == FINISH);
   assign dma_req     = (state_reg == LOAD);
   assign kernel_en   = (state_reg == RUN);
   assign status      = status_reg;
   assign iter_count  = iter_reg;
   assign result_bank = bank_reg;
   assign ping        = ping_reg;

`ifdef SPMV_ITER_CTRL_PERF_EN
   logic [31:0] perf_cycles_reg;
   logic [31:0] perf_stall_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cycles_reg <= '0;
         perf_stall_reg  <= '0;
      end else if ((state_reg == IDLE) && start) begin
         perf_cycles_reg <= '0;
         perf_stall_reg  <= '0;
      end else begin
         if (busy) begin
            perf_cycles_reg <= perf_cycles_reg + 32'd1;
         end
         if ((state_reg == LOAD) && !dma_ack) begin
            perf_stall_reg <= perf_stall_reg + 32'd1;
         end
      end
   end

   assign perf_cycles = perf_cycles_reg;
   assign perf_stall  = perf_stall_reg;
`endif

endmodule

// File: tb/tb_spmv_iter_ctrl.sv
// Scoreboard bench for spmv_iter_ctrl: reactive DMA/kernel models, per-run expectations from a
// phase-level reference model, and a monitor that checks every completion.
module tb_spmv_iter_ctrl;

   localparam int IW   = 16;
   localparam int TO   = 10;
   localparam int MAXI = 8;

   logic          clk;
   logic          rst;
   logic          start;
   logic          abort;
   logic [IW-1:0] num_iters;
   logic          busy;
   logic          done;
   logic [1:0]    status;
   logic [IW-1:0] iter_count;
   logic          result_bank;
   logic          ping;
   logic          kernel_en;
   logic          kernel_done;
   logic          dma_req;
   logic          dma_ack;
`ifdef SPMV_ITER_CTRL_PERF_EN
   logic [31:0]   perf_cycles;
   logic [31:0]   perf_stall;
`endif

   spmv_iter_ctrl #(
      .ITER_WIDTH    (IW),
      .TIMEOUT_CYCLES(TO),
      .TIMEOUT_WIDTH (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .num_iters  (num_iters),
      .busy       (busy),
      .done       (done),
      .status     (status),
      .iter_count (iter_count),
      .result_bank(result_bank),
      .ping       (ping),
      .kernel_en  (kernel_en),
      .kernel_done(kernel_done),
      .dma_req    (dma_req),
`ifdef SPMV_ITER_CTRL_PERF_EN
      .perf_cycles(perf_cycles),
      .perf_stall (perf_stall),
`endif
      .dma_ack    (dma_ack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int status;
      int iters;
      int bank;
      int busy_cyc;
      int dma_cyc;
      int ken_cyc;
      int stall;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   errors   = 0;
   int   done_cnt = 0;
   int   ack_delay[MAXI];
   int   lat[MAXI];
   int   abort_iter;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Phase-level model: each iteration costs a LOAD of (delay+1) cycles, a RUN of the kernel
   // latency (capped by the watchdog), and one SWAP cycle; the run ends with one FINISH cycle.
   function automatic exp_t model(input int n);
      exp_t e;
      e.status   = 0;
      e.iters    = n;
      e.bank     = n % 2;
      e.busy_cyc = 1;
      e.dma_cyc  = 0;
      e.ken_cyc  = 0;
      e.stall    = 0;
      for (int k = 0; k < n; k++) begin
         e.dma_cyc  += ack_delay[k] + 1;
         e.stall    += ack_delay[k];
         e.busy_cyc += ack_delay[k] + 1;
         if (lat[k] > TO) begin
            e.ken_cyc  += TO;
            e.busy_cyc += TO;
            e.status    = 2;
            e.iters     = k;
            e.bank      = k % 2;
            break;
         end
         e.ken_cyc  += lat[k];
         e.busy_cyc += lat[k];
         if (k == abort_iter) begin
            e.status = 1;
            e.iters  = k;
            e.bank   = k % 2;
            break;
         end
         e.busy_cyc += 1;
      end
      return e;
   endfunction

   // Reactive DMA and kernel models, driven away from the active edge.
   initial begin : env
      int env_iter;
      int req_cnt;
      int run_cnt;
      env_iter    = 0;
      req_cnt     = 0;
      run_cnt     = 0;
      dma_ack     = 1'b0;
      kernel_done = 1'b0;
      abort       = 1'b0;
      forever begin
         @(negedge clk);
         if (busy !== 1'b1) begin
            env_iter    = 0;
            req_cnt     = 0;
            run_cnt     = 0;
            dma_ack     = 1'b0;
            kernel_done = 1'b0;
            abort       = 1'b0;
         end else begin
            if (dma_req) begin
               dma_ack = (req_cnt >= ack_delay[env_iter % MAXI]);
               req_cnt++;
            end else begin
               dma_ack = 1'b0;
               req_cnt = 0;
            end
            if (kernel_en) begin
               run_cnt++;
               kernel_done = (run_cnt == lat[env_iter % MAXI]);
               abort       = kernel_done && (env_iter == abort_iter);
            end else begin
               if (run_cnt != 0) env_iter++;
               run_cnt     = 0;
               kernel_done = 1'b0;
               abort       = 1'b0;
            end
         end
      end
   end

   // Monitor: accumulates per-run activity and checks it when done is presented.
   initial begin : mon
      int   busy_c;
      int   dma_c;
      int   ken_c;
      int   run_k;
      bit   prev_ken;
      exp_t e;
      busy_c   = 0;
      dma_c    = 0;
      ken_c    = 0;
      run_k    = 0;
      prev_ken = 1'b0;
      forever begin
         @(negedge clk);
         if (busy !== 1'b1) begin
            busy_c   = 0;
            dma_c    = 0;
            ken_c    = 0;
            run_k    = 0;
            prev_ken = 1'b0;
         end else begin
            busy_c++;
            if (dma_req) dma_c++;
            if (kernel_en) begin
               ken_c++;
               if (!prev_ken) begin
                  chk("ping_in_run", int'(ping), run_k % 2);
                  chk("iter_in_run", int'(iter_count), run_k);
                  run_k++;
               end
            end
            prev_ken = kernel_en;
            if (done) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: got done with status %0d, expected no completion",
                           status);
               end else begin
                  e = sb.pop_front();
                  chk("status", int'(status), e.status);
                  chk("iter_count", int'(iter_count), e.iters);
                  chk("result_bank", int'(result_bank), e.bank);
                  chk("busy_cycles", busy_c, e.busy_cyc);
                  chk("dma_req_cycles", dma_c, e.dma_cyc);
                  chk("kernel_en_cycles", ken_c, e.ken_cyc);
`ifdef SPMV_ITER_CTRL_PERF_EN
                  chk("perf_cycles", int'(perf_cycles), e.busy_cyc - 1);
                  chk("perf_stall", int'(perf_stall), e.stall);
`endif
                  $display("done #%0d: status=%0d iter_count=%0d result_bank=%0d busy=%0d dma=%0d ken=%0d",
                           done_cnt, status, iter_count, result_bank, busy_c, dma_c, ken_c);
               end
               done_cnt++;
               busy_c = 0;
               dma_c  = 0;
               ken_c  = 0;
               run_k  = 0;
            end
         end
      end
   end

   task automatic set_cfg(input int ack, input int l);
      for (int i = 0; i < MAXI; i++) begin
         ack_delay[i] = ack;
         lat[i]       = l;
      end
   endtask

   task automatic run_one(input int n, input bit stray);
      int   target;
      exp_t e;
      e = model(n);
      sb.push_back(e);
      target    = done_cnt + 1;
      num_iters = IW'(n);
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      num_iters = IW'($urandom);
      for (int c = 0; c < 2000 && done_cnt < target; c++) begin
         start = stray && (c == 2) && (busy === 1'b1);
         if (start) num_iters = IW'($urandom_range(1, 7));
         @(negedge clk);
      end
      start = 1'b0;
      if (done_cnt < target) begin
         checks++;
         errors++;
         $display("FAIL run_timeout: no done within 2000 cycles, expected one for num_iters=%0d", n);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic reset_during_run();
      int d0;
      bit seen;
      set_cfg(0, 6);
      abort_iter = -1;
      num_iters  = IW'(3);
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen  = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         if (kernel_en && (iter_count == IW'(1))) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL reset_wait: got no second kernel run in 100 cycles, expected one");
      end
      d0  = done_cnt;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_outputs", int'({busy, done, status, iter_count, result_bank, ping, kernel_en, dma_req}), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("rst_no_done", done_cnt, d0);
   endtask

   initial begin : watchdog_guard
      #500000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "bench time limit reached");
   end

   initial begin : main
      int n;
      rst        = 1'b1;
      start      = 1'b0;
      num_iters  = '0;
      abort_iter = -1;
      set_cfg(0, 5);
      repeat (3) @(negedge clk);
      chk("reset_outputs", int'({busy, done, status, iter_count, result_bank, ping, kernel_en, dma_req}), 0);
      rst = 1'b0;
      @(negedge clk);

      set_cfg(0, 6);
      run_one(3, 1'b0);
      run_one(0, 1'b0);
      set_cfg(4, 3);
      run_one(2, 1'b0);
      set_cfg(0, 100);
      run_one(1, 1'b0);
      set_cfg(0, 5);
      abort_iter = 1;
      run_one(4, 1'b0);
      abort_iter = -1;
      reset_during_run();
      set_cfg(1, 4);
      run_one(3, 1'b1);

      for (int r = 0; r < 20; r++) begin
         n = int'($urandom_range(0, 5));
         for (int i = 0; i < MAXI; i++) begin
            ack_delay[i] = int'($urandom_range(0, 3));
            lat[i]       = int'($urandom_range(1, 12));
         end
         abort_iter = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
         run_one(n, 1'(($urandom_range(0, 1))));
      end
      abort_iter = -1;
      repeat (5) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
